perceptron_uart_ctrl: RTL and testbench

UART command sequencer that sits between the UART byte receiver/transmitter and the perceptron datapath inside the perceptron top level. It parses host command bytes and writes weights, bias and inputs into the core's register banks. It launches an inference, waits for completion, and returns a one-byte response per command. It is the only master of the core's load and start interface.

---
 rtl/perceptron_uart_ctrl_if.sv | 29 ++
 rtl/perceptron_uart_ctrl.sv | 142 ++++++++++++++
 tb/tb_perceptron_uart_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_uart_ctrl_if.sv
// Byte-stream, core-bank and core-control signals of the perceptron UART sequencer.
// master = sequencer side, slave = UART/core side.
interface perceptron_uart_ctrl_if #(
    parameter int AW = 2
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          mem_we;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          core_start;
    logic          core_done;
    logic          core_class;
    logic          busy;

    modport master (
        input  rx_data, rx_valid, tx_busy, core_done, core_class,
        output tx_data, tx_start, mem_we, mem_sel, mem_addr, mem_data, core_start, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, core_done, core_class,
        input  tx_data, tx_start, mem_we, mem_sel, mem_addr, mem_data, core_start, busy
    );
endinterface

// File: rtl/perceptron_uart_ctrl.sv
// Host command sequencer for the perceptron core: loads weights/inputs, runs inference, replies one byte.
// Optional payload inter-byte timeout: define PERCEPTRON_CTRL_TIMEOUT_EN.
module perceptron_uart_ctrl #(
    parameter int N_INPUTS       = 2,
    parameter int TIMEOUT_CYCLES = 120000,
    parameter int AW             = $clog2(N_INPUTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    perceptron_uart_ctrl_if.master bus
);
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_X   = 8'h58;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h54;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, RUN, WAIT_DONE, SEND} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] last_idx;
    logic [7:0]    rsp, rsp_nxt;
    logic          we, we_nxt;
    logic          sel, sel_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [7:0]    data, data_nxt;
    logic          loading;
    logic          timeout;

    assign loading  = (state == LOAD_W) || (state == LOAD_X);
    assign last_idx = (state == LOAD_W) ? AW'(N_INPUTS) : AW'(N_INPUTS - 1);

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap;

    // gap counts consecutive idle cycles spent in a load state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= '0;
        end else if (loading && !bus.rx_valid) begin
            gap <= gap + 1'b1;
        end else begin
            gap <= '0;
        end
    end

    assign timeout = loading && !bus.rx_valid && (gap == GW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rsp   <= '0;
            we    <= 1'b0;
            sel   <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rsp   <= rsp_nxt;
            we    <= we_nxt;
            sel   <= sel_nxt;
            addr  <= addr_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rsp_nxt   = rsp;
        we_nxt    = 1'b0;
        sel_nxt   = sel;
        addr_nxt  = addr;
        data_nxt  = data;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_W: begin
                            state_nxt = LOAD_W;
                            cnt_nxt   = '0;
                        end
                        CMD_X: begin
                            state_nxt = LOAD_X;
                            cnt_nxt   = '0;
                        end
                        CMD_R:   state_nxt = RUN;
                        default: begin
                            state_nxt = SEND;
                            rsp_nxt   = RSP_BAD;
                        end
                    endcase
                end
            end
            LOAD_W, LOAD_X: begin
                if (bus.rx_valid) begin
                    we_nxt   = 1'b1;
                    sel_nxt  = (state == LOAD_X);
                    addr_nxt = cnt;
                    data_nxt = bus.rx_data;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == last_idx) begin
                        state_nxt = SEND;
                        rsp_nxt   = RSP_OK;
                    end
                end else if (timeout) begin
                    state_nxt = SEND;
                    rsp_nxt   = RSP_TO;
                end
            end
            RUN: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.core_done) begin
                    state_nxt = SEND;
                    rsp_nxt   = {7'h18, bus.core_class};
                end
            end
            SEND: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx_start is combinational so a free transmitter fires in the first SEND cycle
    assign bus.tx_data    = rsp;
    assign bus.tx_start   = (state == SEND) && !bus.tx_busy;
    assign bus.core_start = (state == RUN);
    assign bus.busy       = (state != IDLE);
    assign bus.mem_we     = we;
    assign bus.mem_sel    = sel;
    assign bus.mem_addr   = addr;
    assign bus.mem_data   = data;
endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Randomized self-checking bench for perceptron_uart_ctrl against a transaction-level reference model.
module tb_perceptron_uart_ctrl;
    localparam int N   = 2;
    localparam int AWL = 2;
`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 120000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    perceptron_uart_ctrl_if #(.AW(AWL)) bus_if ();

    perceptron_uart_ctrl #(
        .N_INPUTS      (N),
        .TIMEOUT_CYCLES(TO),
        .AW            (AWL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sel;
        int         addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } rsp_t;

    wr_t        exp_wr[$];
    rsp_t       exp_rsp[$];
    int         exp_start[$];
    logic [7:0] fixed_pl[$];
    logic [7:0] last_rsp = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;
    wr_t        mw;
    rsp_t       mr;
    int         ms;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every observed event must match the oldest expected one, including its cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.mem_we) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    mw = exp_wr.pop_front();
                    chk("wr_sel", bus_if.mem_sel, mw.sel);
                    chk("wr_addr", bus_if.mem_addr, mw.addr);
                    chk("wr_data", bus_if.mem_data, mw.data);
                    chk("wr_cyc", cyc, mw.cyc);
                end
            end
            if (bus_if.tx_start) begin
                chk("tx_while_busy", bus_if.tx_busy, 0);
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
                if (exp_rsp.size() > 0) begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_byte", bus_if.tx_data, mr.b);
                    if (mr.cyc >= 0) chk("rsp_cyc", cyc, mr.cyc);
                    last_rsp = mr.b;
                end
            end
            if (bus_if.core_start) begin
                chk("start_expected", 32'(exp_start.size() > 0), 1);
                if (exp_start.size() > 0) begin
                    ms = exp_start.pop_front();
                    chk("start_cyc", cyc, ms);
                end
            end
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'($urandom);
    endtask

    task automatic do_load(input bit is_x, input int hold, input int maxgap);
        int         t;
        int         n;
        logic [7:0] p;
        n = is_x ? N : N + 1;
        send_byte(is_x ? 8'h58 : 8'h57, t);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, maxgap));
            p = (fixed_pl.size() > 0) ? fixed_pl.pop_front() : 8'($urandom);
            if (i == n - 1 && hold > 0) bus_if.tx_busy = 1'b1;
            send_byte(p, t);
            exp_wr.push_back('{is_x, i, p, t + 1});
        end
        exp_rsp.push_back('{8'h4B, t + 1 + hold});
        if (hold > 0) begin
            tick(hold);
            bus_if.tx_busy = 1'b0;
        end
        tick(1 + $urandom_range(0, 2));
    endtask

    task automatic do_run(input bit cls, input int hold, input bit drop);
        int t;
        int td;
        send_byte(8'h52, t);
        exp_start.push_back(t + 1);
        if (drop) begin
            tick(1);
            send_byte(8'h57, td);
            chk("busy_wait", bus_if.busy, 1);
            tick(3);
        end else begin
            tick(5);
        end
        bus_if.core_done  = 1'b1;
        bus_if.core_class = cls;
        if (hold > 0) bus_if.tx_busy = 1'b1;
        tick(1);
        bus_if.core_done  = 1'b0;
        bus_if.core_class = 1'($urandom_range(0, 1));
        exp_rsp.push_back('{{7'h18, cls}, t + 7 + hold});
        if (hold > 0) begin
            tick(hold);
            bus_if.tx_busy = 1'b0;
        end
        tick(1 + $urandom_range(0, 2));
    endtask

    task automatic do_bad(input logic [7:0] b, input int hold);
        int t;
        if (hold > 0) bus_if.tx_busy = 1'b1;
        send_byte(b, t);
        exp_rsp.push_back('{8'h3F, t + 1 + hold});
        if (hold > 0) begin
            tick(hold);
            bus_if.tx_busy = 1'b0;
        end
        tick(1 + $urandom_range(0, 2));
    endtask

    task automatic do_stray();
        bus_if.core_done  = 1'b1;
        bus_if.core_class = 1'($urandom_range(0, 1));
        tick(1);
        bus_if.core_done = 1'b0;
        chk("stray_idle", bus_if.busy, 0);
        tick(1);
    endtask

    task automatic check_reset_vals();
        chk("rst_tx_start", bus_if.tx_start, 0);
        chk("rst_mem_we", bus_if.mem_we, 0);
        chk("rst_core_start", bus_if.core_start, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_tx_data", bus_if.tx_data, 0);
        chk("rst_mem_sel", bus_if.mem_sel, 0);
        chk("rst_mem_addr", bus_if.mem_addr, 0);
        chk("rst_mem_data", bus_if.mem_data, 0);
    endtask

    initial begin
        int         t;
        int         hold;
        logic [7:0] b;

        bus_if.rx_data    = 8'h00;
        bus_if.rx_valid   = 1'b0;
        bus_if.tx_busy    = 1'b0;
        bus_if.core_done  = 1'b0;
        bus_if.core_class = 1'b0;

        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // directed scenarios
        fixed_pl = '{8'h05, 8'hFD, 8'h02};
        do_load(1'b0, 0, 0);
        do_run(1'b1, 0, 1'b0);
        do_run(1'b0, 0, 1'b0);
        do_load(1'b1, 50, 0);
        do_bad(8'h41, 0);
        do_run(1'b1, 0, 1'b1);
        do_stray();

`ifdef PERCEPTRON_CTRL_TIMEOUT_EN
        send_byte(8'h58, t);
        send_byte(8'h07, t);
        exp_wr.push_back('{1'b1, 0, 8'h07, t + 1});
        exp_rsp.push_back('{8'h54, -1});
        tick(90);
        chk("no_early_timeout", exp_rsp.size(), 1);
        for (int i = 0; i < 300 && exp_rsp.size() > 0; i++) tick(1);
        chk("timeout_rsp_seen", exp_rsp.size(), 0);
        tick(1);
        do_run(1'b1, 0, 1'b0);
`else
        send_byte(8'h58, t);
        send_byte(8'h07, t);
        exp_wr.push_back('{1'b1, 0, 8'h07, t + 1});
        tick(150);
        chk("load_waits", bus_if.busy, 1);
        send_byte(8'h09, t);
        exp_wr.push_back('{1'b1, 1, 8'h09, t + 1});
        exp_rsp.push_back('{8'h4B, t + 1});
        tick(2);
`endif

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            case ($urandom_range(0, 5))
                0: do_load(1'b0, hold, 2);
                1: do_load(1'b1, hold, 2);
                2: do_run(1'($urandom_range(0, 1)), hold, 1'($urandom_range(0, 1)));
                3: begin
                    do begin
                        b = 8'($urandom);
                    end while (b == 8'h57 || b == 8'h58 || b == 8'h52);
                    do_bad(b, hold);
                end
                4: do_stray();
                default: begin
                    fixed_pl = '{8'h52, 8'h57, 8'h58};
                    do_load(1'b0, hold, 0);
                end
            endcase
        end

        // asynchronous reset in the middle of a weight load
        send_byte(8'h57, t);
        send_byte(8'h11, t);
        exp_wr.push_back('{1'b0, 0, 8'h11, t + 1});
        tick(1);
        chk("midload_busy", bus_if.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        do_load(1'b1, 0, 1);

        tick(5);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("start_queue_empty", exp_start.size(), 0);
        chk("end_busy", bus_if.busy, 0);
        chk("tx_data_hold", bus_if.tx_data, last_rsp);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
